// File: rtl/keyboard_buf_pkg.sv
// Shared constants for the keyboard character buffer: default geometry and
// the pointer/count widths derived from it.
package keyboard_buf_pkg;

   localparam int KB_DEPTH  = 16;
   localparam int KB_DATA_W = 7;
   localparam int KB_PTR_W  = $clog2(KB_DEPTH);
   localparam int KB_CNT_W  = KB_PTR_W + 1;

endpackage : keyboard_buf_pkg

// File: rtl/keyboard_buf_rise.sv
// kb_rise_detect: one-cycle pulse on the rising edge of a level input.
// Sample register clears on reset so a level held across release reads as an edge.
module kb_rise_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic level,
   output logic rise
);

   logic level_q_r;

   // Previous-cycle sample of the level input
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         level_q_r <= 1'b0;
      end else begin
         level_q_r <= level;
      end
   end

   assign rise = level & ~level_q_r;

endmodule : kb_rise_detect

// File: rtl/keyboard_buf.sv
// Keyboard character FIFO between a serial receiver and a consumer.
// Optional macro KEYBOARD_BUF_DROP_OLDEST_EN: overflow overwrites the oldest entry
// instead of dropping the incoming character.
module keyboard_buf
   import keyboard_buf_pkg::*;
#(
   parameter int DEPTH  = KB_DEPTH,
   parameter int DATA_W = KB_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_done,
   input  logic              KB_read_en,
   input  logic              KB_clear,
   output logic              KB_status,
   output logic [DATA_W-1:0] KB_data,
   output logic              buf_full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [CNT_W-1:0]  cnt_r;

   logic [PTR_W-1:0]  wr_ptr_nxt_s;
   logic [PTR_W-1:0]  rd_ptr_nxt_s;
   logic [CNT_W-1:0]  cnt_nxt_s;
   logic              push_s;
   logic              pop_s;
   logic              do_push_s;
   logic              do_pop_s;
   logic              overwrite_s;
   logic              full_s;
   logic              empty_s;
   logic              rx_msb_unused_s;

   assign rx_msb_unused_s = rx_data[7];

   kb_rise_detect u_rx_rise (
      .clk   (clk),
      .rst_n (rst_n),
      .level (rx_done),
      .rise  (push_s)
   );

   kb_rise_detect u_rd_rise (
      .clk   (clk),
      .rst_n (rst_n),
      .level (KB_read_en),
      .rise  (pop_s)
   );

   // Accept/reject decisions and next pointer/count values
   always_comb begin
      full_s       = (cnt_r == CNT_W'(DEPTH));
      empty_s      = (cnt_r == {CNT_W{1'b0}});
      do_pop_s     = pop_s & ~empty_s;
`ifdef KEYBOARD_BUF_DROP_OLDEST_EN
      do_push_s    = push_s;
      overwrite_s  = push_s & full_s & ~do_pop_s;
`else
      do_push_s    = push_s & (~full_s | do_pop_s);
      overwrite_s  = 1'b0;
`endif
      wr_ptr_nxt_s = wr_ptr_r;
      rd_ptr_nxt_s = rd_ptr_r;
      cnt_nxt_s    = cnt_r;
      if (do_push_s) begin
         wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
      end else begin
         wr_ptr_nxt_s = wr_ptr_r;
      end
      if (do_pop_s || overwrite_s) begin
         rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
      end else begin
         rd_ptr_nxt_s = rd_ptr_r;
      end
      // An overwrite is a push paired with an implicit pop, so count holds
      case ({do_push_s & ~overwrite_s, do_pop_s})
         2'b10:   cnt_nxt_s = cnt_r + CNT_W'(1);
         2'b01:   cnt_nxt_s = cnt_r - CNT_W'(1);
         default: cnt_nxt_s = cnt_r;
      endcase
   end

   // Pointer and count registers; reset beats clear beats push/pop
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         cnt_r    <= {CNT_W{1'b0}};
      end else if (KB_clear) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         cnt_r    <= {CNT_W{1'b0}};
      end else begin
         wr_ptr_r <= wr_ptr_nxt_s;
         rd_ptr_r <= rd_ptr_nxt_s;
         cnt_r    <= cnt_nxt_s;
      end
   end

   // Character storage; contents survive reset and clear
   always_ff @(posedge clk) begin
      if (rst_n && !KB_clear && do_push_s) begin
         mem_r[wr_ptr_r] <= rx_data[DATA_W-1:0];
      end
   end

   assign KB_status = ~empty_s;
   assign buf_full  = full_s;
   assign KB_data   = empty_s ? {DATA_W{1'b0}} : mem_r[rd_ptr_r];

endmodule : keyboard_buf

// File: tb/tb_keyboard_buf.sv
// Self-checking bench for keyboard_buf: a queue model of the FIFO holds the
// characters expected at the head, compared as the consumer pops them.
module tb_keyboard_buf;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       KB_read_en;
   logic       KB_clear;
   logic       KB_status;
   logic [6:0] KB_data;
   logic       buf_full;

   int errors = 0;
   int checks = 0;
   logic [6:0] exp_q [$];
   logic [6:0] exp_c;

   keyboard_buf dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_data    (rx_data),
      .rx_done    (rx_done),
      .KB_read_en (KB_read_en),
      .KB_clear   (KB_clear),
      .KB_status  (KB_status),
      .KB_data    (KB_data),
      .buf_full   (buf_full)
   );

   always #5 clk = ~clk;

   task automatic model_push(input logic [7:0] b);
      if (exp_q.size() < 16) begin
         exp_q.push_back(b[6:0]);
      end else begin
`ifdef KEYBOARD_BUF_DROP_OLDEST_EN
         void'(exp_q.pop_front());
         exp_q.push_back(b[6:0]);
`endif
      end
   endtask

   task automatic push_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data = b;
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
      model_push(b);
   endtask

   task automatic pulse_read();
      @(negedge clk);
      KB_read_en = 1'b1;
      @(negedge clk);
      KB_read_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rx_data = 8'h00; rx_done = 1'b0; KB_read_en = 1'b0; KB_clear = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      exp_q.delete();
      checks++; if (KB_status !== 1'b0) begin errors++; $display("FAIL reset_status: got %0b want 0", KB_status); end
      checks++; if (buf_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b want 0", buf_full); end
      checks++; if (KB_data !== 7'h00) begin errors++; $display("FAIL reset_data: got %h want 00", KB_data); end
   endtask

   task automatic test_single_push();
      push_byte(8'h68);
      checks++; if (KB_status !== 1'b1) begin errors++; $display("FAIL single_status: got %0b want 1", KB_status); end
      checks++; if (KB_data !== 7'h68) begin errors++; $display("FAIL single_data: got %h want 68", KB_data); end
      checks++; if (buf_full !== 1'b0) begin errors++; $display("FAIL single_full: got %0b want 0", buf_full); end
      pulse_read();
      void'(exp_q.pop_front());
      checks++; if (KB_status !== 1'b0) begin errors++; $display("FAIL single_drain: got %0b want 0", KB_status); end
   endtask

   task automatic test_hello();
      logic [7:0] msg [11] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
                               8'h77, 8'h6F, 8'h72, 8'h6C, 8'h64};
      foreach (msg[i]) push_byte(msg[i]);
      for (int i = 0; i < 11; i++) begin
         exp_c = exp_q.pop_front();
         checks++; if (KB_data !== exp_c) begin errors++; $display("FAIL hello_char%0d: got %h want %h", i, KB_data, exp_c); end
         pulse_read();
      end
      checks++; if (KB_status !== 1'b0) begin errors++; $display("FAIL hello_status: got %0b want 0", KB_status); end
      checks++; if (KB_data !== 7'h00) begin errors++; $display("FAIL hello_data: got %h want 00", KB_data); end
   endtask

   task automatic test_long_strobe();
      @(negedge clk);
      rx_data = 8'hE5;
      rx_done = 1'b1;
      repeat (3) @(negedge clk);
      rx_done = 1'b0;
      model_push(8'hE5);
      checks++; if (KB_data !== 7'h65) begin errors++; $display("FAIL long_data: got %h want 65", KB_data); end
      pulse_read();
      void'(exp_q.pop_front());
      checks++; if (KB_status !== 1'b0) begin errors++; $display("FAIL long_single_entry: got %0b want 0", KB_status); end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 16; i++) push_byte(8'h41 + 8'(i));
      checks++; if (buf_full !== 1'b1) begin errors++; $display("FAIL ovf_full16: got %0b want 1", buf_full); end
      push_byte(8'h51);
      checks++; if (buf_full !== 1'b1) begin errors++; $display("FAIL ovf_full17: got %0b want 1", buf_full); end
`ifdef KEYBOARD_BUF_DROP_OLDEST_EN
      checks++; if (KB_data !== 7'h42) begin errors++; $display("FAIL ovf_head: got %h want 42", KB_data); end
`else
      checks++; if (KB_data !== 7'h41) begin errors++; $display("FAIL ovf_head: got %h want 41", KB_data); end
`endif
      for (int i = 0; i < 16; i++) begin
         exp_c = exp_q.pop_front();
         checks++; if (KB_data !== exp_c) begin errors++; $display("FAIL ovf_pop%0d: got %h want %h", i, KB_data, exp_c); end
         pulse_read();
      end
      checks++; if (KB_status !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %0b want 0", KB_status); end
   endtask

   task automatic test_clear();
      push_byte(8'h65);
      @(negedge clk);
      KB_clear = 1'b1;
      @(negedge clk);
      KB_clear = 1'b0;
      exp_q.delete();
      checks++; if (KB_status !== 1'b0) begin errors++; $display("FAIL clear_status: got %0b want 0", KB_status); end
      checks++; if (KB_data !== 7'h00) begin errors++; $display("FAIL clear_data: got %h want 00", KB_data); end
      pulse_read();
      checks++; if (KB_status !== 1'b0) begin errors++; $display("FAIL clear_pop_empty: got %0b want 0", KB_status); end
      push_byte(8'h33);
      checks++; if (KB_data !== 7'h33) begin errors++; $display("FAIL clear_then_push: got %h want 33", KB_data); end
      pulse_read();
      void'(exp_q.pop_front());
   endtask

   task automatic test_empty_simul();
      // Push and pop together while empty: only the push takes effect
      @(negedge clk);
      rx_data = 8'h31; rx_done = 1'b1; KB_read_en = 1'b1;
      @(negedge clk);
      rx_done = 1'b0; KB_read_en = 1'b0;
      model_push(8'h31);
      checks++; if (KB_status !== 1'b1) begin errors++; $display("FAIL empty_simul_status: got %0b want 1", KB_status); end
      checks++; if (KB_data !== 7'h31) begin errors++; $display("FAIL empty_simul_data: got %h want 31", KB_data); end
      pulse_read();
      void'(exp_q.pop_front());
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 16; i++) push_byte(8'h41 + 8'(i));
      @(negedge clk);
      rx_data = 8'h7A; rx_done = 1'b1; KB_read_en = 1'b1;
      @(negedge clk);
      rx_done = 1'b0; KB_read_en = 1'b0;
      void'(exp_q.pop_front());
      exp_q.push_back(7'h7A);
      checks++; if (buf_full !== 1'b1) begin errors++; $display("FAIL b2b_full: got %0b want 1", buf_full); end
      checks++; if (KB_data !== 7'h42) begin errors++; $display("FAIL b2b_head: got %h want 42", KB_data); end
      for (int i = 0; i < 16; i++) begin
         exp_c = exp_q.pop_front();
         checks++; if (KB_data !== exp_c) begin errors++; $display("FAIL b2b_pop%0d: got %h want %h", i, KB_data, exp_c); end
         pulse_read();
      end
      checks++; if (KB_status !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %0b want 0", KB_status); end
   endtask

   task automatic test_reset_held();
      push_byte(8'h55);
      @(negedge clk);
      rst_n = 1'b0; rx_data = 8'h2A; rx_done = 1'b1;
      repeat (2) @(negedge clk);
      exp_q.delete();
      checks++; if (KB_status !== 1'b0) begin errors++; $display("FAIL rst_held_empty: got %0b want 0", KB_status); end
      rst_n = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
      model_push(8'h2A);
      checks++; if (KB_data !== 7'h2A) begin errors++; $display("FAIL rst_held_push: got %h want 2a", KB_data); end
      pulse_read();
      void'(exp_q.pop_front());
      checks++; if (KB_status !== 1'b0) begin errors++; $display("FAIL rst_held_once: got %0b want 0", KB_status); end
   endtask

   initial begin
      test_reset();
      test_single_push();
      test_hello();
      test_long_strobe();
      test_overflow();
      test_clear();
      test_empty_simul();
      test_back_to_back();
      test_reset_held();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_keyboard_buf
